// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Produces one quotient bit per cycle and holds the pipeline with stall_req while busy.
// result = {remainder (HI), quotient (LO)}.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on leaving this state
// ZERO  | divisor was zero; one cycle to form the fixed divide-by-zero result
// ON    | iterating, one quotient bit per cycle for WIDTH cycles
// END   | result registered, ready pulses for this single cycle
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic                 stall_req,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_e;

    state_e               state_q, state_d;
    // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 qsign_q, qsign_d;
    logic                 rsign_q, rsign_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    // Partial remainder after the shift is WIDTH+1 bits so the trial difference keeps its sign
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       diff;
    logic                 qbit;
    logic [WIDTH-1:0]     abs_a, abs_b;

    // Next-state, datapath iteration and result formation
    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        abs_a   = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + ONE) : opdata1;
        abs_b   = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + ONE) : opdata2;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        qbit    = ~diff[WIDTH];

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (opdata2 == '0) begin
                        state_d = ZERO;
                        dvd_d   = opdata1;
                    end else begin
                        state_d = ON;
                        dvd_d   = abs_a;
                        dvs_d   = abs_b;
                        qsign_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        rsign_d = signed_div & opdata1[WIDTH-1];
                        cnt_d   = '0;
                        rem_d   = '0;
                    end
                end
            end
            ZERO: begin
                state_d  = END;
                result_d = {dvd_q, {WIDTH{1'b1}}};
            end
            ON: begin
                rem_d = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = END;
                    result_d = {rsign_q ? (~rem_d + ONE) : rem_d,
                                qsign_q ? (~dvd_d + ONE) : dvd_d};
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over everything and leaves the last result untouched
        if (annul) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign ready     = (state_q == END) && !annul;
    assign stall_req = start & ~ready & ~annul;
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized DIV/DIVU
// operations checked against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        stall_req;
    logic        ready;
    logic [63:0] result;

    int          checks = 0;
    int          passed = 0;
    logic [63:0] exp_last = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .stall_req  (stall_req),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    // MIPS division semantics from plain arithmetic
    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Runs one operation from an idle cycle; operands are scrambled after cycle 0.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output int lat, output logic [63:0] res, output int stall_bad);
        lat = -1;
        res = 'x;
        stall_bad = 0;
        start = 1'b1;
        opdata1 = a;
        opdata2 = b;
        signed_div = sgn;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                res = result;
                if (stall_req !== 1'b0) stall_bad++;
                break;
            end
            if (stall_req !== 1'b1) stall_bad++;
            @(posedge clk); #1;
            opdata1 = $urandom;
            opdata2 = $urandom;
            signed_div = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else passed++;
        checks++; if (result !== 64'd0) $display("FAIL reset_result: got %h want 0", result); else passed++;
        resetn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (stall_req !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_req); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", ready); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        int lat; logic [63:0] res; int sb;
        run_div(32'd100, 32'd7, 1'b0, lat, res, sb);
        checks++; if (lat !== 33) $display("FAIL divu_latency: got %0d want 33", lat); else passed++;
        checks++; if (res !== {32'd2, 32'd14}) $display("FAIL divu_result: got %h want %h", res, {32'd2, 32'd14}); else passed++;
        checks++; if (sb !== 0) $display("FAIL divu_stall: %0d bad stall cycles want 0", sb); else passed++;
        exp_last = {32'd2, 32'd14};
    endtask

    task automatic test_div_signed();
        int lat; logic [63:0] res; int sb;
        run_div(32'hFFFFFFF9, 32'h00000002, 1'b1, lat, res, sb);
        checks++; if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) $display("FAIL div_neg7_2: got %h want ffffffff_fffffffd", res); else passed++;
        checks++; if (lat !== 33) $display("FAIL div_neg_latency: got %0d want 33", lat); else passed++;
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, res, sb);
        checks++; if (res !== {32'h00000000, 32'h80000000}) $display("FAIL div_overflow: got %h want 00000000_80000000", res); else passed++;
        exp_last = {32'h00000000, 32'h80000000};
    endtask

    task automatic test_div_zero();
        int lat; logic [63:0] res; int sb;
        run_div(32'd5, 32'd0, 1'b0, lat, res, sb);
        checks++; if (lat !== 2) $display("FAIL divz_latency: got %0d want 2", lat); else passed++;
        checks++; if (res !== {32'h00000005, 32'hFFFFFFFF}) $display("FAIL divz_u_result: got %h want 00000005_ffffffff", res); else passed++;
        checks++; if (sb !== 0) $display("FAIL divz_stall: %0d bad stall cycles want 0", sb); else passed++;
        run_div(32'hFFFFFFFB, 32'd0, 1'b1, lat, res, sb);
        checks++; if (res !== {32'hFFFFFFFB, 32'hFFFFFFFF}) $display("FAIL divz_s_result: got %h want fffffffb_ffffffff", res); else passed++;
        exp_last = {32'hFFFFFFFB, 32'hFFFFFFFF};
    endtask

    task automatic test_annul();
        int lat; logic [63:0] res; int sb; int rdy_seen;
        rdy_seen = 0;
        start = 1'b1; signed_div = 1'b0;
        opdata1 = 32'hFFFFFFFF; opdata2 = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready) rdy_seen++;
            @(posedge clk); #1;
        end
        annul = 1'b1;
        @(negedge clk);
        checks++; if (stall_req !== 1'b0) $display("FAIL annul_stall: got %b want 0", stall_req); else passed++;
        @(posedge clk); #1;
        annul = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) rdy_seen++;
            @(posedge clk); #1;
        end
        checks++; if (rdy_seen !== 0) $display("FAIL annul_no_ready: got %0d pulses want 0", rdy_seen); else passed++;
        checks++; if (result !== exp_last) $display("FAIL annul_result_hold: got %h want %h", result, exp_last); else passed++;
        run_div(32'd9, 32'd3, 1'b0, lat, res, sb);
        checks++; if (lat !== 33) $display("FAIL after_annul_latency: got %0d want 33", lat); else passed++;
        checks++; if (res !== {32'd0, 32'd3}) $display("FAIL after_annul_result: got %h want 00000000_00000003", res); else passed++;
        exp_last = {32'd0, 32'd3};
    endtask

    task automatic test_back_to_back();
        int first; int second;
        logic [63:0] r1; logic [63:0] r2;
        first = -1; second = -1; r1 = 'x; r2 = 'x;
        start = 1'b1; signed_div = 1'b0;
        opdata1 = 32'd8; opdata2 = 32'd2;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (ready) begin
                if (first < 0) begin
                    first = c; r1 = result;
                end else begin
                    second = c; r2 = result;
                    break;
                end
            end
            @(posedge clk); #1;
            if (first == c) begin
                opdata1 = 32'd9; opdata2 = 32'd4;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (first !== 33) $display("FAIL b2b_first_cycle: got %0d want 33", first); else passed++;
        checks++; if (r1 !== {32'd0, 32'd4}) $display("FAIL b2b_first_result: got %h want 00000000_00000004", r1); else passed++;
        checks++; if (second !== 67) $display("FAIL b2b_second_cycle: got %0d want 67", second); else passed++;
        checks++; if (r2 !== {32'd1, 32'd2}) $display("FAIL b2b_second_result: got %h want 00000001_00000002", r2); else passed++;
        exp_last = {32'd1, 32'd2};
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] res; int sb;
        logic [31:0] a; logic [31:0] b;
        start = 1'b1; signed_div = 1'b0;
        opdata1 = 32'd1000; opdata2 = 32'd7;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) $display("FAIL midreset_ready: got %b want 0", ready); else passed++;
        checks++; if (result !== 64'd0) $display("FAIL midreset_result: got %h want 0", result); else passed++;
        start = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        a = $urandom; b = $urandom_range(1, 1000);
        run_div(a, b, 1'b1, lat, res, sb);
        checks++; if (lat !== 33) $display("FAIL postreset_latency: got %0d want 33", lat); else passed++;
        checks++; if (res !== ref_div(a, b, 1'b1)) $display("FAIL postreset_result: got %h want %h", res, ref_div(a, b, 1'b1)); else passed++;
        exp_last = ref_div(a, b, 1'b1);
    endtask

    task automatic test_random();
        int lat; logic [63:0] res; int sb; int want_lat; int mode;
        logic [31:0] a; logic [31:0] b; logic sgn;
        for (int i = 0; i < 30; i++) begin
            mode = $urandom_range(0, 5);
            case (mode)
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 16);
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            sgn = 1'($urandom_range(0, 1));
            want_lat = (b == 32'd0) ? 2 : 33;
            run_div(a, b, sgn, lat, res, sb);
            checks++; if (res !== ref_div(a, b, sgn)) $display("FAIL rand_result[%0d]: a=%h b=%h s=%b got %h want %h", i, a, b, sgn, res, ref_div(a, b, sgn)); else passed++;
            checks++; if (lat !== want_lat) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, want_lat); else passed++;
            checks++; if (sb !== 0) $display("FAIL rand_stall[%0d]: %0d bad stall cycles want 0", i, sb); else passed++;
            exp_last = ref_div(a, b, sgn);
        end
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        signed_div = 1'b0;
        annul = 1'b0;
        opdata1 = '0;
        opdata2 = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_div_zero();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage; executes MIPS DIV/DIVU.
- Requests a pipeline stall while busy. The stall is consumed by the stage registers with stall/clear controls.
- Produces {HI,LO} for the HI/LO register write in the following stage.
- Radix-2 restoring algorithm, one quotient bit per cycle, fixed latency.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous reset, active low.
- start  input  1  EX stage holds a DIV/DIVU; held high by EX until ready.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- annul  input  1  exception/flush; aborts any operation.
- opdata1  input  WIDTH  dividend (rs).
- opdata2  input  WIDTH  divisor (rt).
- stall_req  output  1  combinational, = start & ~ready & ~annul.
- ready  output  1  result valid, one-cycle pulse.
- result  output  2*WIDTH  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO).

Behaviour:
- Reset (resetn low, async):
  - state = IDLE, ready = 0, result = 0, counter = 0.
  - Applies immediately, including mid-operation.
- States: IDLE, ZERO, ON, END.
- IDLE:
  - If start & ~annul and opdata2 == 0 → ZERO.
  - If start & ~annul and opdata2 != 0 → ON.
  - On entry to ON, latch:
    - absolute values of both operands (negated only when signed_div and MSB = 1);
    - qsign = signed_div & (a[W-1] ^ b[W-1]);
    - rsign = signed_div & a[W-1];
    - counter = 0; partial remainder = 0.
  - Otherwise stay in IDLE.
- ON:
  - Each cycle, shift the next dividend bit (MSB first) into the partial remainder.
  - Trial-subtract |divisor|:
    - non-negative difference → keep the difference, quotient bit = 1;
    - negative difference → restore, quotient bit = 0.
  - counter increments each cycle. After WIDTH iterations → END.
- ZERO: one cycle → END with raw quotient = all ones, raw remainder = opdata1 as latched (no sign fix-up).
- END:
  - ready = 1 for exactly this cycle.
  - result is registered on entry to END:
    - quotient negated if qsign;
    - remainder negated if rsign.
  - Next state is IDLE unconditionally.
- result holds its value until the next END. ready is low in all states except END.
- Latency (start first seen high in cycle 0):
  - normal: ready in cycle WIDTH+1 (33); stall_req high for cycles 0..WIDTH;
  - divide-by-zero: ready in cycle 2.
- annul:
  - Any state → IDLE on the next edge; ready is forced 0 that cycle; result is unchanged.
  - start is ignored while annul is high.
- Back-to-back: start still high in the cycle after END (a new instruction in EX) begins a new operation from IDLE. There are no extra bubbles beyond the IDLE cycle.
- Operands are sampled only on the IDLE→ON/ZERO transition. Operand changes during ON are ignored.
- Signed overflow: 0x80000000 / 0xFFFFFFFF (signed) → quotient 0x80000000, remainder 0; this falls out of the unsigned magnitude path.
- Widths:
  - internal partial remainder is WIDTH+1 bits to hold the trial-subtract sign;
  - counter is clog2(WIDTH)+1 bits.

Test Plan:
- DIVU 100/7, start held → stall_req high in cycles 0–32; ready pulse in cycle 33; result = {0x00000002, 0x0000000E}; stall_req low in cycle 33.
- DIV −7/2 (0xFFFFFFF9 / 0x00000002) → result = {0xFFFFFFFF, 0xFFFFFFFD}. Also DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- DIVU 5/0 → ready in cycle 2, result = {0x00000005, 0xFFFFFFFF}. DIV −5/0 → {0xFFFFFFFB, 0xFFFFFFFF}.
- Start DIVU 0xFFFFFFFF / 3, assert annul in cycle 10 → no ready pulse, state IDLE in cycle 11, result keeps its prior value. A new DIVU 9/3 then gives {0, 3} after 33 cycles.
- Two DIVU back-to-back (8/2 then 9/4), start continuously high → first ready in cycle 33 with {0, 4}, second ready in cycle 67 with {1, 2}.
- Drop resetn low in cycle 15 of an operation → ready = 0 and result = 0 immediately (asynchronous, before the next edge), state IDLE. After release, a fresh operation completes normally.
